chronos_fetch: RTL and testbench

Parametrised instruction-fetch stage for the Chronos RV32I core. It replaces the bare PC register plus direct instruction-memory hookup. It owns the PC, issues word requests to instruction memory over a valid/ready channel, and tracks in-order responses. Fetched instructions are buffered with their PCs in a small FIFO for decode. A redirect path serves branches and jumps: it flushes buffered and in-flight fetches.

---
 rtl/chronos_pkg.sv | 13 +
 rtl/chronos_sync_fifo.sv | 49 ++++
 rtl/chronos_fetch.sv | 93 +++++++++
 tb/tb_chronos_fetch.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/chronos_pkg.sv
// Shared constants and types for the Chronos RV32I front end.
package chronos_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/chronos_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, synchronous flush and an occupancy count.
module chronos_sync_fifo
  import chronos_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Same slot index with differing wrap bits means the writer lapped the reader.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/chronos_fetch.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word requests,
// buffers in-order responses with their PCs and supports flush-on-redirect.
module chronos_fetch #(
  parameter int              XLEN     = chronos_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(chronos_pkg::RESET_PC),
  parameter int              DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [XLEN-1:0]               imem_req_addr,
  input  logic                          imem_rsp_valid,
  input  logic [chronos_pkg::ILEN-1:0]  imem_rsp_data,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [chronos_pkg::ILEN-1:0]  out_inst,
  output logic [XLEN-1:0]               out_pc
);
  import chronos_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]      fetch_pc, rsp_pc, target;
  logic [CW-1:0]        inflight, drop, fifo_count;
  logic                 fifo_empty, fifo_full;
  logic                 rsp_fire, rsp_keep, req_fire, push, pop;
  logic [XLEN+ILEN-1:0] wdata, rdata;

  assign target   = {redirect_pc[XLEN-1:2], 2'b00};
  assign rsp_fire = imem_rsp_valid && (inflight != '0);
  assign rsp_keep = rsp_fire && (drop == '0);

  // Buffered plus outstanding never exceeds DEPTH, so every response has a slot.
  assign imem_req_valid = rst && !redirect_valid &&
                          (({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push      = rsp_keep && !redirect_valid;
  assign out_valid = rst && !fifo_empty;
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign wdata     = {rsp_pc, imem_rsp_data};
  assign {out_pc, out_inst} = rdata;

  chronos_sync_fifo #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(rsp_fire);
      if (redirect_valid) begin
        fetch_pc <= target;
        rsp_pc   <= target;
        // Everything still outstanding after this cycle's response is stale.
        drop     <= inflight - CW'(rsp_fire);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (push)     rsp_pc   <= rsp_pc + XLEN'(4);
        if (rsp_fire && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(imem_rsp_valid && (inflight == '0)));
      assert (!$isunknown(redirect_valid));
      assert (!(push && fifo_full));
    end
  end

endmodule

// File: tb/tb_chronos_fetch.sv
// Bench for chronos_fetch: directed table, hand-written corner sequences and a
// random phase, all checked against a request-tracking reference model.
module tb_chronos_fetch;
  import chronos_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_inst, out_pc;

  always #5 clk = ~clk;

  chronos_fetch #(.XLEN(32), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;

  typedef struct packed {
    logic        rr, orr, erv;
    logic [31:0] eaddr;
    logic        eov;
    logic [31:0] epc;
  } vec_t;

  mreq_t        mq[$];
  vec_t         tbl[12];
  int           total = 0, bad = 0, cyc = 0, buffered = 0, mem_delay = 1, pops = 0;
  logic [31:0]  exp_req_addr = RPC, exp_out_pc = RPC;
  logic         rst_req = 1'b0;
  logic         s_req_valid, s_out_valid, s_rsp;
  logic [31:0]  s_req_addr;
  fetch_entry_t s_head;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic rr, input logic orr, input logic rv, input logic [31:0] rpc);
    logic  exp_rv, exp_ov, fire, popd;
    int    d;
    mreq_t e;
    @(negedge clk);
    rst            = rst_req;
    imem_req_ready = rr;
    out_ready      = orr;
    redirect_valid = rv;
    redirect_pc    = rpc;
    s_rsp          = rst_req && (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rsp_valid = s_rsp;
    imem_rsp_data  = s_rsp ? inst_of(mq[0].addr) : $urandom;
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_out_valid = out_valid;
    s_head      = {out_pc, out_inst};

    exp_rv = rst_req && !rv && ((buffered + mq.size()) < DEPTH);
    exp_ov = rst_req && (buffered > 0);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("out_pc", out_pc, exp_out_pc);
      chk("out_inst", out_inst, inst_of(exp_out_pc));
    end
    fire = exp_rv && rr;
    if (fire) chk("req_addr", imem_req_addr, exp_req_addr);
    popd = exp_ov && orr && !rv;

    if (!rst_req) begin
      mq.delete();
      buffered     = 0;
      exp_req_addr = RPC;
      exp_out_pc   = RPC;
    end else begin
      if (s_rsp) begin
        e = mq.pop_front();
        if (!e.stale && !rv) buffered++;
      end
      if (rv) begin
        foreach (mq[i]) mq[i].stale = 1'b1;
        buffered     = 0;
        exp_req_addr = {rpc[31:2], 2'b00};
        exp_out_pc   = {rpc[31:2], 2'b00};
      end else begin
        if (popd) begin
          buffered--;
          exp_out_pc += 32'd4;
          pops++;
        end
        if (fire) begin
          d = (mem_delay > 0) ? mem_delay : int'($urandom_range(1, 3));
          mq.push_back('{exp_req_addr, cyc + d, 1'b0});
          exp_req_addr += 32'd4;
        end
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    int          found;
    logic [31:0] first_pc;
    imem_req_ready = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    // Reset held for two cycles: both outputs must stay low.
    rst_req = 1'b0;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    rst_req   = 1'b1;
    mem_delay = 1;

    // rr, orr, req_valid, req_addr, out_valid, out_pc (1-cycle memory)
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h10c, 1'b1, 32'h104};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h110, 1'b1, 32'h108};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h114, 1'b1, 32'h108};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h108};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h118, 1'b1, 32'h10c};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10c};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10c};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rr, tbl[i].orr, 1'b0, 32'h0);
      chk($sformatf("tbl%0d req_valid", i), 32'(s_req_valid), 32'(tbl[i].erv));
      if (tbl[i].erv) chk($sformatf("tbl%0d req_addr", i), s_req_addr, tbl[i].eaddr);
      chk($sformatf("tbl%0d out_valid", i), 32'(s_out_valid), 32'(tbl[i].eov));
      if (tbl[i].eov) chk($sformatf("tbl%0d out_pc", i), s_head.pc, tbl[i].epc);
    end

    // Three requests in flight, then redirect to an unaligned target.
    mem_delay = 5;
    step(1'b0, 1'b0, 1'b1, 32'h3000);
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h2002);
    mem_delay = 1;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir req_valid", 32'(s_req_valid), 32'd1);
    chk("redir req_addr", s_req_addr, 32'h2000);
    chk("redir out_valid", 32'(s_out_valid), 32'd0);
    found = 0;
    first_pc = '0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (s_out_valid) begin
        found    = 1;
        first_pc = s_head.pc;
      end
    end
    chk("redir first out seen", 32'(found), 32'd1);
    chk("redir first out_pc", first_pc, 32'h2000);

    // Redirect coinciding with a response and a pop.
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h4000);
    chk("combo rsp present", 32'(s_rsp), 32'd1);
    chk("combo pop present", 32'(s_out_valid), 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("combo out_valid", 32'(s_out_valid), 32'd0);
    chk("combo req_addr", s_req_addr, 32'h4000);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Reset with buffered entries and requests still in flight.
    mem_delay = 3;
    step(1'b0, 1'b0, 1'b1, 32'h5000);
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("pre-reset out_valid", 32'(s_out_valid), 32'd1);
    rst_req = 1'b0;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("in-reset req_valid", 32'(s_req_valid), 32'd0);
    chk("in-reset out_valid", 32'(s_out_valid), 32'd0);
    rst_req = 1'b1;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("post-reset req_valid", 32'(s_req_valid), 32'd1);
    chk("post-reset req_addr", s_req_addr, RPC);

    // Random backpressure, 1-3 cycle memory and occasional redirects.
    mem_delay = 0;
    pops      = 0;
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 29) == 0), $urandom);
    chk("random pops >= 3*DEPTH", 32'(pops >= 3 * DEPTH), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
